// File: rtl/battleship_pkg.sv
// Shared types and helpers for the battleship placement logic.
package battleship_pkg;

  localparam int BOARD_N = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EDIT  = 2'd1,
    WRITE = 2'd2,
    PULSE = 2'd3
  } state_t;

  // Ship lengths by index; indices past the fleet map to 0 (no ship).
  function automatic logic [2:0] ship_len(input logic [2:0] idx);
    case (idx)
      3'd0:    ship_len = 3'd2;
      3'd1:    ship_len = 3'd3;
      3'd2:    ship_len = 3'd3;
      3'd3:    ship_len = 3'd4;
      3'd4:    ship_len = 3'd5;
      default: ship_len = 3'd0;
    endcase
  endfunction

  function automatic int cell_idx(input int row, input int col, input int n);
    cell_idx = row * n + col;
  endfunction

endpackage

// File: rtl/ship_cursor_placer_footprint_check.sv
// Combinational footprint mask and validity for a ship at (row, col).
module footprint_check
  import battleship_pkg::*;
#(
  parameter int N  = BOARD_N,
  parameter int RW = $clog2(N),
  parameter int NC = N * N
) (
  input  logic [RW-1:0] i_row,
  input  logic [RW-1:0] i_col,
  input  logic          i_horizontal,
  input  logic [2:0]    i_len,
  input  logic [NC-1:0] i_occ,
  output logic [NC-1:0] o_mask,
  output logic          o_valid
);

  logic w_oob;

  always_comb begin
    int r, c, l;
    o_mask = '0;
    r      = int'(i_row);
    c      = int'(i_col);
    l      = int'(i_len);
    w_oob  = i_horizontal ? (c + l > N) : (r + l > N);
    for (int i = 0; i < NC; i++) begin
      if (i_horizontal)
        o_mask[i] = ((i / N) == r) && ((i % N) >= c) && ((i % N) < c + l);
      else
        o_mask[i] = ((i % N) == c) && ((i / N) >= r) && ((i / N) < r + l);
    end
  end

  assign o_valid = (i_len != 3'd0) && !w_oob && ((o_mask & i_occ) == '0);

endmodule

// File: rtl/ship_cursor_placer.sv
// Placement cursor, footprint check, occupancy writer and place strobe.
module ship_cursor_placer
  import battleship_pkg::*;
#(
  parameter int BOARD_N   = battleship_pkg::BOARD_N,
  parameter int MAX_SHIPS = 5,
  localparam int RW = $clog2(BOARD_N),
  localparam int NC = BOARD_N * BOARD_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          placing_ships,
  input  logic [2:0]    ships_placed,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_rotate,
  input  logic          btn_place,
  output logic [RW-1:0] cursor_row,
  output logic [RW-1:0] cursor_col,
  output logic          horizontal,
  output logic          place_valid,
  output logic [NC-1:0] preview_mask,
  output logic [NC-1:0] board_occ,
  output logic          busy,
  output logic          place_ship_n
);

  state_t        r_state, w_nxt;
  logic [RW-1:0] r_row, r_col, r_wr_row, r_wr_col;
  logic          r_horiz, r_wr_horiz, r_place_n;
  logic [NC-1:0] r_occ;
  logic [2:0]    r_wr_len, r_wr_cnt;

  logic [2:0]    w_len;
  logic [NC-1:0] w_mask, w_wr_mask;
  logic          w_valid, w_accept, w_rot, w_up, w_down, w_left, w_right, w_last;

  assign w_len = (int'(ships_placed) <= MAX_SHIPS) ? ship_len(ships_placed) : 3'd0;

  footprint_check #(.N(BOARD_N)) u_fp (
    .i_row        (r_row),
    .i_col        (r_col),
    .i_horizontal (r_horiz),
    .i_len        (w_len),
    .i_occ        (r_occ),
    .o_mask       (w_mask),
    .o_valid      (w_valid)
  );

  // One button per cycle; an invalid place press swallows the cycle.
  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_rot    = 1'b0;
    w_up     = 1'b0;
    w_down   = 1'b0;
    w_left   = 1'b0;
    w_right  = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: if (placing_ships) w_nxt = EDIT;
      EDIT: begin
        if (!placing_ships) w_nxt = IDLE;
        else if (btn_place) begin
          if (w_valid) begin
            w_accept = 1'b1;
            w_nxt    = WRITE;
          end
        end
        else if (btn_rotate) w_rot   = 1'b1;
        else if (btn_up)     w_up    = 1'b1;
        else if (btn_down)   w_down  = 1'b1;
        else if (btn_left)   w_left  = 1'b1;
        else if (btn_right)  w_right = 1'b1;
      end
      WRITE: begin
        w_last = (r_wr_cnt == r_wr_len - 3'd1);
        if (w_last) w_nxt = PULSE;
      end
      PULSE: w_nxt = placing_ships ? EDIT : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    int idx;
    idx = cell_idx(int'(r_wr_row) + (r_wr_horiz ? 0 : int'(r_wr_cnt)),
                   int'(r_wr_col) + (r_wr_horiz ? int'(r_wr_cnt) : 0), BOARD_N);
    w_wr_mask = '0;
    for (int i = 0; i < NC; i++) w_wr_mask[i] = (i == idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_horiz    <= 1'b1;
      r_occ      <= '0;
      r_place_n  <= 1'b1;
      r_wr_row   <= '0;
      r_wr_col   <= '0;
      r_wr_horiz <= 1'b1;
      r_wr_len   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_state   <= w_nxt;
      r_place_n <= !((r_state == WRITE) && w_last);
      if (w_accept) begin
        r_wr_row   <= r_row;
        r_wr_col   <= r_col;
        r_wr_horiz <= r_horiz;
        r_wr_len   <= w_len;
        r_wr_cnt   <= '0;
      end
      if (r_state == WRITE) begin
        r_occ    <= r_occ | w_wr_mask;
        r_wr_cnt <= r_wr_cnt + 3'd1;
      end
      if (w_rot) r_horiz <= ~r_horiz;
      if (w_up    && r_row != '0)             r_row <= r_row - RW'(1);
      if (w_down  && r_row != RW'(BOARD_N-1)) r_row <= r_row + RW'(1);
      if (w_left  && r_col != '0)             r_col <= r_col - RW'(1);
      if (w_right && r_col != RW'(BOARD_N-1)) r_col <= r_col + RW'(1);
    end
  end

  assign cursor_row   = r_row;
  assign cursor_col   = r_col;
  assign horizontal   = r_horiz;
  assign place_valid  = w_valid;
  assign preview_mask = (r_state == EDIT) ? w_mask : '0;
  assign board_occ    = r_occ;
  assign busy         = (r_state == WRITE) || (r_state == PULSE);
  assign place_ship_n = r_place_n;

endmodule
